scoreboard_register_file: RTL

Parametrised general-purpose register file for the 16-bit CPU datapath, generalising the current 4 x 16-bit file.
- Two combinational read ports and one clocked write port.
- Optional write-through bypass and optional hardwired-zero register 0.
- Per-register busy scoreboard so the control unit can reserve a destination for a multicycle operation (e.g. multiply, memory load) and detect operand readiness.
- Sits between instruction decode (RS/RT/RD fields) and the ALU/writeback mux.

---
 rtl/scoreboard_register_file.sv | 78 +++++++
 1 files changed

// File: rtl/scoreboard_register_file.sv
// rtl/scoreboard_register_file.sv - parametrised register file with per-register busy scoreboard
module scoreboard_register_file #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 2,
  parameter int BYPASS     = 1,
  parameter int ZERO_REG   = 0
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic [ADDR_WIDTH-1:0]        RS,
  input  logic [ADDR_WIDTH-1:0]        RT,
  input  logic [ADDR_WIDTH-1:0]        RD,
  input  logic [DATA_WIDTH-1:0]        WriteData,
  input  logic                         RegWrite,
  input  logic                         Reserve,
  input  logic [ADDR_WIDTH-1:0]        ReserveRD,
  output logic [DATA_WIDTH-1:0]        ReadRS,
  output logic [DATA_WIDTH-1:0]        ReadRT,
  output logic                         RSReady,
  output logic                         RTReady,
  output logic [(2**ADDR_WIDTH)-1:0]   Busy
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0]   busy_q;
  logic                  write_ok;
  logic                  reserve_ok;

  assign write_ok   = RegWrite && !((ZERO_REG != 0) && (RD == '0));
  assign reserve_ok = Reserve && !((ZERO_REG != 0) && (ReserveRD == '0));

  // Reserve is applied after the write clear so a same-index reserve leaves the register busy.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      if (write_ok) begin
        regs[RD]   <= WriteData;
        busy_q[RD] <= 1'b0;
      end
      if (reserve_ok) begin
        busy_q[ReserveRD] <= 1'b1;
      end
    end
  end

  always_comb begin
    ReadRS  = regs[RS];
    RSReady = ~busy_q[RS];
    if ((ZERO_REG != 0) && (RS == '0)) begin
      ReadRS  = '0;
      RSReady = 1'b1;
    end else if ((BYPASS != 0) && RegWrite && (RD == RS)) begin
      ReadRS  = WriteData;
      RSReady = 1'b1;
    end
  end

  always_comb begin
    ReadRT  = regs[RT];
    RTReady = ~busy_q[RT];
    if ((ZERO_REG != 0) && (RT == '0)) begin
      ReadRT  = '0;
      RTReady = 1'b1;
    end else if ((BYPASS != 0) && RegWrite && (RD == RT)) begin
      ReadRT  = WriteData;
      RTReady = 1'b1;
    end
  end

  assign Busy = busy_q;

endmodule
